// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control logic.
package mips_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/mips_fwd_unit.sv
// EX operand forwarding select for one source register; EX/MEM beats MEM/WB.
module mips_fwd_unit
    import mips_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_reg_write,
    output logic [1:0]    fwd_sel_c
);

    always_comb begin
        fwd_sel_c = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
            fwd_sel_c = FWD_EXMEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
            fwd_sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline sequencer: load-use / branch / MDU stall and flush control,
// EX forwarding selects and saturating stall/flush counters.
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_mdu_op,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              pc_redirect,
    output logic              mdu_start,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned BUSY_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

    hz_state_t         state_q, state_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_use;
    logic [1:0]        fwd_a_c, fwd_b_c;

    mips_fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .src           (ex_rs),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel_c     (fwd_a_c)
    );

    mips_fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .src           (ex_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel_c     (fwd_b_c)
    );

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    // Next state, control outputs and counter updates; reset forces a bubbled, frozen front end.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pc_redirect = 1'b0;
        mdu_start   = 1'b0;
        fwd_a       = fwd_a_c;
        fwd_b       = fwd_b_c;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_mdu_op) begin
                    mdu_start  = 1'b1;
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    busy_d     = BUSY_W'(MDU_LAT - 1);
                    state_d    = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                if (ex_branch_taken) begin
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    busy_d      = '0;
                    state_d     = RUN;
                end else if (busy_q == '0) begin
                    state_d = RUN;
                end else begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    busy_d     = busy_q - BUSY_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                busy_d  = '0;
            end
        endcase

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pc_redirect = 1'b0;
            mdu_start   = 1'b0;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (pc_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            busy_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed-vector bench for mips_hazard_ctrl, plus multi-cycle MDU/reset/saturation sequences.
module tb_mips_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, id_mdu_op, ex_mem_read, ex_branch_taken;
    logic       mem_reg_write, wb_reg_write;

    logic        pc_en, ifid_en, ifid_flush, idex_flush, pc_redirect, mdu_start;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_pc_redirect, s_mdu_start;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int n_vec;
    int n_err;

    mips_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu_op(id_mdu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pc_redirect(pc_redirect), .mdu_start(mdu_start), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    mips_hazard_ctrl #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu_op(id_mdu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .pc_redirect(s_pc_redirect), .mdu_start(s_mdu_start), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] id_rs, id_rt;
        logic       use_rs, use_rt, mdu;
        logic [4:0] ex_rs, ex_rt, ex_rd;
        logic       mem_read, br;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic [9:0] exp;   // {pc_en, ifid_en, ifid_flush, idex_flush, redirect, mdu_start, fwd_a, fwd_b}
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(string n, logic [4:0] irs, logic [4:0] irt, logic ur, logic ut,
                                logic md, logic [4:0] ers, logic [4:0] ert, logic [4:0] erd,
                                logic mr, logic br, logic [4:0] mrd, logic mwe,
                                logic [4:0] wrd, logic wwe, logic [9:0] e);
        vec_t v;
        v.name = n; v.id_rs = irs; v.id_rt = irt; v.use_rs = ur; v.use_rt = ut; v.mdu = md;
        v.ex_rs = ers; v.ex_rt = ert; v.ex_rd = erd; v.mem_read = mr; v.br = br;
        v.mem_rd = mrd; v.mem_we = mwe; v.wb_rd = wrd; v.wb_we = wwe; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_mdu_op = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        id_rs = v.id_rs; id_rt = v.id_rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        id_mdu_op = v.mdu; ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd;
        ex_mem_read = v.mem_read; ex_branch_taken = v.br; mem_rd = v.mem_rd;
        mem_reg_write = v.mem_we; wb_rd = v.wb_rd; wb_reg_write = v.wb_we;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [9:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_flush, pc_redirect, mdu_start, fwd_a, fwd_b};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0]  = mk("idle",          0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 10'b1100_00_00_00);
        vecs[1]  = mk("luse_rs",       2, 0, 1, 0, 0,  0, 0, 2, 1, 0,  0, 0, 0, 0, 10'b0001_00_00_00);
        vecs[2]  = mk("luse_rt",       0, 7, 0, 1, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0, 10'b0001_00_00_00);
        vecs[3]  = mk("ld_rs_unused",  2, 0, 0, 0, 0,  0, 0, 2, 1, 0,  0, 0, 0, 0, 10'b1100_00_00_00);
        vecs[4]  = mk("not_a_load",    2, 0, 1, 0, 0,  0, 0, 2, 0, 0,  0, 0, 0, 0, 10'b1100_00_00_00);
        vecs[5]  = mk("ld_r0",         0, 0, 1, 1, 0,  0, 0, 0, 1, 0,  0, 0, 0, 0, 10'b1100_00_00_00);
        vecs[6]  = mk("fwd_exmem",     0, 0, 0, 0, 0,  2, 2, 0, 0, 0,  2, 1, 0, 0, 10'b1100_00_10_10);
        vecs[7]  = mk("fwd_exmem_pri", 0, 0, 0, 0, 0,  2, 2, 0, 0, 0,  2, 1, 2, 1, 10'b1100_00_10_10);
        vecs[8]  = mk("fwd_memwb",     0, 0, 0, 0, 0,  3, 4, 0, 0, 0,  9, 1, 3, 1, 10'b1100_00_01_00);
        vecs[9]  = mk("fwd_r0",        0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 10'b1100_00_00_00);
        vecs[10] = mk("fwd_mem_nowe",  0, 0, 0, 0, 0,  5, 6, 0, 0, 0,  5, 0, 5, 1, 10'b1100_00_01_00);
        vecs[11] = mk("fwd_b_only",    0, 0, 0, 0, 0,  1, 8, 0, 0, 0,  8, 1, 0, 0, 10'b1100_00_00_10);
        vecs[12] = mk("br_over_luse",  2, 0, 1, 0, 0,  0, 0, 2, 1, 1,  0, 0, 0, 0, 10'b1111_10_00_00);
        vecs[13] = mk("br_over_mdu",   0, 0, 0, 0, 1,  0, 0, 0, 0, 1,  0, 0, 0, 0, 10'b1111_10_00_00);

        clear_inputs();
        rst = 1'b1;
        #3;
        chk("rst_outputs", 32'(outs()), 32'(10'b0011_00_00_00));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        do_reset();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            step();
        end

        // lw $2 ; add $3,$2,$4: one stall, then MEM/WB forward
        do_reset();
        id_rs = 5'd2; id_use_rs = 1'b1; ex_rd = 5'd2; ex_mem_read = 1'b1;
        #1;
        chk("t1_stall", 32'({pc_en, idex_flush}), 32'(2'b01));
        step();
        clear_inputs();
        ex_rs = 5'd2; wb_rd = 5'd2; wb_reg_write = 1'b1;
        #1;
        chk("t1_fwd_a", 32'(fwd_a), 32'(2'b01));
        chk("t1_pc_en", 32'(pc_en), 32'd1);
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd1);

        // branch beats load-use
        do_reset();
        id_rs = 5'd2; id_use_rs = 1'b1; ex_rd = 5'd2; ex_mem_read = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("t3_outs", 32'(outs()), 32'(10'b1111_10_00_00));
        step();
        clear_inputs();
        #1;
        chk("t3_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd0);

        // mult: one start pulse, four stall cycles, then advance
        do_reset();
        id_mdu_op = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t4_mdu_start_c%0d", c), 32'(mdu_start), (c == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t4_pc_en_c%0d", c), 32'(pc_en), (c == 4) ? 32'd1 : 32'd0);
            step();
        end
        id_mdu_op = 1'b0;
        #1;
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("t4_pc_en_after", 32'(pc_en), 32'd1);

        // reset 2 cycles into MDU_BUSY, then pending mult re-issues
        do_reset();
        id_mdu_op = 1'b1;
        ex_rs = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_outs", 32'(outs()), 32'(10'b0011_00_00_00));
        chk("t5_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_reissue", 32'({mdu_start, pc_en}), 32'(2'b10));
        step();
        clear_inputs();

        // branch aborts MDU_BUSY
        do_reset();
        id_mdu_op = 1'b1;
        step();
        id_mdu_op = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        chk("t_abort_outs", 32'(outs()), 32'(10'b1111_10_00_00));
        step();
        ex_branch_taken = 1'b0;
        #1;
        chk("t_abort_run", 32'({pc_en, mdu_start, idex_flush}), 32'(3'b100));

        // counter saturation on the 3-bit instance
        do_reset();
        id_rs = 5'd4; id_use_rs = 1'b1; ex_rd = 5'd4; ex_mem_read = 1'b1;
        repeat (9) step();
        clear_inputs();
        #1;
        chk("t6_sat_small", 32'(s_stall_cnt), 32'd7);
        chk("t6_full_wide", 32'(stall_cnt), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
